// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache controller: controller
// states and helpers that derive address-field widths from the parameters.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOOKUP     = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } cache_state_e;

  // Width of an index that selects one of n items, never narrower than 1 bit.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned off_bits(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned word_bits(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned index_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_w,
                                           input int unsigned data_w,
                                           input int unsigned words,
                                           input int unsigned sets);
    return addr_w - off_bits(data_w) - word_bits(words) - index_bits(sets);
  endfunction

  function automatic int unsigned plru_bits(input int unsigned ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set tree pseudo-LRU: reports the victim way of the selected set and
// steers that set's tree away from the way named on an update.
module cache_plru
  import cache_pkg::*;
#(
  parameter  int unsigned WAYS  = 2,
  parameter  int unsigned SETS  = 64,
  localparam int unsigned IDX_W = index_bits(SETS),
  localparam int unsigned WAY_W = bits_for(WAYS),
  localparam int unsigned PB_W  = plru_bits(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] set_i,
  input  logic             upd_i,
  input  logic [WAY_W-1:0] upd_way_i,
  output logic [WAY_W-1:0] victim_o
);

  logic [PB_W-1:0] tree_q [SETS];
  logic [PB_W-1:0] tree_d;
  logic [PB_W-1:0] cur;

  assign cur = tree_q[set_i];

  // Bit 0 is the root (0 = left half is older); bits 1/2 pick within each half.
  if (WAYS == 4) begin : g_four
    always_comb begin
      tree_d    = cur;
      victim_o  = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
      tree_d[0] = ~upd_way_i[1];
      if (upd_way_i[1]) tree_d[2] = ~upd_way_i[0];
      else              tree_d[1] = ~upd_way_i[0];
    end
  end else if (WAYS == 2) begin : g_two
    assign victim_o = cur;
    assign tree_d   = ~upd_way_i;
  end else begin : g_one
    logic unused_plru;
    assign victim_o    = '0;
    assign tree_d      = '0;
    assign unused_plru = ^{cur, upd_way_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else if (upd_i) begin
      tree_q[set_i] <= tree_d;
    end
  end

endmodule

// File: rtl/set_assoc_cache_controller.sv
// Write-back, write-allocate set-associative cache controller with a
// single-cycle hit path and word-serial burst refill/write-back.
module set_assoc_cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 64,
  parameter int unsigned WORDS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_data_in,
  input  logic                mem_ready
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = off_bits(DATA_W);
  localparam int unsigned WRD_W = word_bits(WORDS);
  localparam int unsigned IDX_W = index_bits(SETS);
  localparam int unsigned TAG_W = tag_bits(ADDR_W, DATA_W, WORDS, SETS);
  localparam int unsigned WAY_W = bits_for(WAYS);
  localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(WORDS - 1);

  cache_state_e      state_q, state_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [IDX_W-1:0]  req_idx_q, req_idx_d;
  logic [WRD_W-1:0]  req_word_q, req_word_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [BE_W-1:0]   req_be_q, req_be_d;
  logic              req_wr_q, req_wr_d;
  logic [WRD_W-1:0]  beat_q, beat_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] data_q  [WAYS][SETS][WORDS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];

  logic              hit, has_invalid, victim_dirty, last_beat, fill_done;
  logic [WAY_W-1:0]  hit_way, free_way, plru_victim, miss_victim;
  logic [DATA_W-1:0] hit_word;
  logic              plru_upd;
  logic [WAY_W-1:0]  plru_way;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^cpu_address[OFF_W-1:0];

  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    has_invalid = 1'b0;
    free_way    = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx_q] && (tag_q[w][req_idx_q] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Scan downwards so the lowest-numbered invalid way wins.
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!valid_q[w-1][req_idx_q]) begin
        has_invalid = 1'b1;
        free_way    = WAY_W'(w - 1);
      end
    end
  end

  assign hit_word     = data_q[hit_way][req_idx_q][req_word_q];
  assign miss_victim  = has_invalid ? free_way : plru_victim;
  assign victim_dirty = dirty_q[miss_victim][req_idx_q];
  assign last_beat    = (beat_q == LAST_BEAT);
  assign fill_done    = (state_q == ALLOCATE) && mem_ready && last_beat;

  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    req_word_d  = req_word_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    req_wr_d    = req_wr_q;
    beat_d      = beat_q;
    victim_d    = victim_q;
    case (state_q)
      IDLE: begin
        if (cpu_read || cpu_write) begin
          req_tag_d   = cpu_address[ADDR_W-1 -: TAG_W];
          req_idx_d   = cpu_address[OFF_W+WRD_W +: IDX_W];
          req_word_d  = cpu_address[OFF_W +: WRD_W];
          req_wdata_d = cpu_wdata;
          req_be_d    = cpu_be;
          req_wr_d    = cpu_write;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          state_d = IDLE;
        end else begin
          victim_d = miss_victim;
          state_d  = victim_dirty ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK, ALLOCATE: begin
        if (mem_ready) begin
          beat_d = beat_q + WRD_W'(1);
          if (last_beat) begin
            beat_d  = '0;
            state_d = (state_q == WRITE_BACK) ? ALLOCATE : LOOKUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready       = (state_q == LOOKUP) && hit;
    cpu_rdata   = (ready && !req_wr_q) ? hit_word : rdata_q;
    mem_read    = (state_q == ALLOCATE);
    mem_write   = (state_q == WRITE_BACK);
    mem_address = '0;
    mem_wdata   = '0;
    if (state_q == WRITE_BACK) begin
      mem_address = {tag_q[victim_q][req_idx_q], req_idx_q, beat_q, {OFF_W{1'b0}}};
      mem_wdata   = data_q[victim_q][req_idx_q][beat_q];
    end else if (state_q == ALLOCATE) begin
      mem_address = {req_tag_q, req_idx_q, beat_q, {OFF_W{1'b0}}};
    end
  end

  assign plru_upd = ready || fill_done;
  assign plru_way = ready ? hit_way : victim_q;

  cache_plru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk_i     (clk),
    .rst_ni    (rst),
    .set_i     (req_idx_q),
    .upd_i     (plru_upd),
    .upd_way_i (plru_way),
    .victim_o  (plru_victim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_word_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_wr_q    <= 1'b0;
      beat_q      <= '0;
      victim_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      req_word_q  <= req_word_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      req_wr_q    <= req_wr_d;
      beat_q      <= beat_d;
      victim_q    <= victim_d;
      rdata_q     <= cpu_rdata;
    end
  end

  // The victim is invalidated as soon as the miss is seen, so a fill cut
  // short by reset or never completed cannot leave a stale line visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      if (state_q == LOOKUP) begin
        if (hit && req_wr_q) begin
          dirty_q[hit_way][req_idx_q] <= 1'b1;
        end else if (!hit) begin
          valid_q[miss_victim][req_idx_q] <= 1'b0;
          dirty_q[miss_victim][req_idx_q] <= 1'b0;
        end
      end
      if (fill_done) valid_q[victim_q][req_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == LOOKUP) && hit && req_wr_q) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (req_be_q[b]) data_q[hit_way][req_idx_q][req_word_q][b*8 +: 8] <= req_wdata_q[b*8 +: 8];
      end
    end
    if ((state_q == ALLOCATE) && mem_ready) begin
      data_q[victim_q][req_idx_q][beat_q] <= mem_data_in;
      if (last_beat) tag_q[victim_q][req_idx_q] <= req_tag_q;
    end
  end

endmodule
